// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, fetches one byte per
// instruction and sequences jump/call/return with a small return stack.
module fetch_sequencer #(
  parameter logic [7:0] RESET_VEC   = 8'h00,
  parameter logic [7:0] STEP        = 8'd4,
  parameter int         STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       stall,
  input  logic       jump_valid,
  input  logic [7:0] jump_target,
  output logic       fetch_req,
  output logic [7:0] fetch_addr,
  input  logic       fetch_ack,
  input  logic [7:0] fetch_data,
  output logic [7:0] instr,
  output logic       instr_valid,
  output logic [7:0] pc,
  output logic       busy,
  output logic       stack_err
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] NEXT = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [7:0]     pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [7:0]     instr_q, instr_d;
  logic           iv_q, iv_d;
  logic [7:0]     stk_q [STACK_DEPTH];

  logic           push;
  logic           fault;
  logic [7:0]     ret_addr;
  logic [7:0]     tgt;
  logic [AW-1:0]  top_idx;

  assign ret_addr = pc_q + STEP;
  assign tgt      = {instr_q[5:0], 2'b00};
  assign top_idx  = sp_q[AW-1:0] - AW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    instr_d = instr_q;
    iv_d    = 1'b0;
    push    = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        if (fetch_ack) begin
          instr_d = fetch_data;
          iv_d    = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (!stall) begin
          // An external redirect overrides the decoded control field.
          if (jump_valid) begin
            pc_d = jump_target;
          end else begin
            unique case (instr_q[7:6])
              2'b00: pc_d = ret_addr;
              2'b01: pc_d = tgt;
              2'b10: begin
                if (sp_q == FULL) begin
                  fault = 1'b1;
                end else begin
                  push = 1'b1;
                  sp_d = sp_q + SPW'(1);
                  pc_d = tgt;
                end
              end
              default: begin
                if (sp_q == '0) begin
                  fault = 1'b1;
                end else begin
                  pc_d = stk_q[top_idx];
                  sp_d = sp_q - SPW'(1);
                end
              end
            endcase
          end
          if (fault) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            state_d = stop ? IDLE : REQ;
          end
        end
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      sp_q    <= '0;
      err_q   <= 1'b0;
      instr_q <= 8'h00;
      iv_q    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      iv_q    <= iv_d;
      if (push) stk_q[sp_q[AW-1:0]] <= ret_addr;
    end
  end

  assign fetch_req   = (state_q == REQ);
  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = iv_q;
  assign busy        = (state_q == REQ) || (state_q == NEXT);
  assign stack_err   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios for the fetch sequencer,
// with a byte-wide instruction memory model driving fetch_data.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       stall;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] pc;
  logic       busy;
  logic       stack_err;

  logic [7:0] mem [256];
  logic       ack_en;
  int         errors;
  int         checks;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .stall(stall), .jump_valid(jump_valid),
    .jump_target(jump_target), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .busy(busy),
    .stack_err(stack_err)
  );

  assign fetch_data = mem[fetch_addr];
  assign fetch_ack  = ack_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    start = 0; stop = 0; stall = 0;
    jump_valid = 0; jump_target = 8'h00; ack_en = 1'b1;
    clear_mem();
    do_reset();
    checks++;
    if (pc !== 8'h00) begin
      errors++; $display("FAIL reset_pc got %h exp 00", pc);
    end
    checks++;
    if (fetch_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got req=%b busy=%b exp 0 0", fetch_req, busy);
    end
    checks++;
    if (instr !== 8'h00 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_instr got %h/%b exp 00/0", instr, instr_valid);
    end
    checks++;
    if (stack_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b exp 0", stack_err);
    end
    tick();
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++; $display("FAIL idle_hold got req=%b exp 0", fetch_req);
    end
  endtask

  task automatic test_sequential;
    logic [7:0] exp;
    clear_mem();
    do_reset();
    start = 1; tick(); start = 0;
    exp = 8'h00;
    for (int i = 0; i <= 64; i++) begin
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== exp) begin
        errors++;
        $display("FAIL seq_addr[%0d] got req=%b addr=%h exp 1 %h",
                 i, fetch_req, fetch_addr, exp);
      end
      tick();
      checks++;
      if (fetch_req !== 1'b0 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_next[%0d] got req=%b iv=%b exp 0 1",
                 i, fetch_req, instr_valid);
      end
      tick();
      exp = exp + 8'd4;
    end
  endtask

  task automatic test_call_ret;
    clear_mem();
    mem[8'h00] = 8'h85;
    mem[8'h14] = 8'hC0;
    mem[8'h04] = 8'h4A;
    do_reset();
    start = 1; tick(); start = 0;
    tick();
    checks++;
    if (instr !== 8'h85) begin
      errors++; $display("FAIL call_instr got %h exp 85", instr);
    end
    tick();
    checks++;
    if (fetch_addr !== 8'h14 || dut.sp_q !== 3'd1) begin
      errors++;
      $display("FAIL call_pc got pc=%h sp=%0d exp 14 1", fetch_addr, dut.sp_q);
    end
    checks++;
    if (dut.stk_q[0] !== 8'h04) begin
      errors++; $display("FAIL call_stack got %h exp 04", dut.stk_q[0]);
    end
    tick();
    tick();
    checks++;
    if (pc !== 8'h04 || dut.sp_q !== 3'd0) begin
      errors++;
      $display("FAIL ret_pc got pc=%h sp=%0d exp 04 0", pc, dut.sp_q);
    end
    tick();
    tick();
    checks++;
    if (pc !== 8'h28 || fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL jump_pc got pc=%h req=%b exp 28 1", pc, fetch_req);
    end
  endtask

  task automatic test_overflow;
    clear_mem();
    mem[8'h00] = 8'h81;
    mem[8'h04] = 8'h82;
    mem[8'h08] = 8'h83;
    mem[8'h0C] = 8'h84;
    mem[8'h10] = 8'h85;
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (fetch_addr !== 8'h10 || dut.sp_q !== 3'd4) begin
      errors++;
      $display("FAIL ovf_pre got addr=%h sp=%0d exp 10 4", fetch_addr, dut.sp_q);
    end
    tick();
    tick();
    checks++;
    if (stack_err !== 1'b1 || fetch_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err got err=%b req=%b busy=%b exp 1 0 0",
               stack_err, fetch_req, busy);
    end
    checks++;
    if (pc !== 8'h10) begin
      errors++; $display("FAIL ovf_pc got %h exp 10", pc);
    end
    start = 1;
    tick(); tick(); tick();
    start = 0;
    checks++;
    if (stack_err !== 1'b1 || fetch_req !== 1'b0 || pc !== 8'h10) begin
      errors++;
      $display("FAIL ovf_start got err=%b req=%b pc=%h exp 1 0 10",
               stack_err, fetch_req, pc);
    end
  endtask

  task automatic test_redirect;
    clear_mem();
    mem[8'h00] = 8'h85;
    do_reset();
    start = 1; tick(); start = 0;
    tick();
    jump_valid = 1; jump_target = 8'h40;
    tick();
    jump_valid = 0;
    checks++;
    if (pc !== 8'h40 || fetch_addr !== 8'h40 || dut.sp_q !== 3'd0) begin
      errors++;
      $display("FAIL redirect got pc=%h addr=%h sp=%0d exp 40 40 0",
               pc, fetch_addr, dut.sp_q);
    end
  endtask

  task automatic test_stall_stop;
    clear_mem();
    do_reset();
    start = 1; tick(); start = 0;
    stall = 1; stop = 1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_first got iv=%b busy=%b exp 1 1", instr_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 8'h00 || instr_valid !== 1'b0 || busy !== 1'b1 ||
          fetch_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got pc=%h iv=%b busy=%b req=%b exp 00 0 1 0",
                 i, pc, instr_valid, busy, fetch_req);
      end
    end
    stall = 0;
    tick();
    stop = 0;
    checks++;
    if (pc !== 8'h04 || busy !== 1'b0 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle got pc=%h busy=%b req=%b exp 04 0 0",
               pc, busy, fetch_req);
    end
    tick();
    checks++;
    if (fetch_req !== 1'b0 || pc !== 8'h04) begin
      errors++;
      $display("FAIL stop_hold got req=%b pc=%h exp 0 04", fetch_req, pc);
    end
  endtask

  task automatic test_handshake;
    clear_mem();
    mem[8'h04] = 8'hAA;
    do_reset();
    ack_en = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== 8'h00 ||
          instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL hs_wait[%0d] got req=%b addr=%h iv=%b exp 1 00 0",
                 i, fetch_req, fetch_addr, instr_valid);
      end
    end
    ack_en = 1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL hs_ack got iv=%b req=%b exp 1 0", instr_valid, fetch_req);
    end
    tick();
    checks++;
    if (fetch_addr !== 8'h04 || fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL hs_req2 got addr=%h req=%b exp 04 1", fetch_addr, fetch_req);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (pc !== 8'h00 || fetch_req !== 1'b0 || dut.sp_q !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got pc=%h req=%b sp=%0d exp 00 0 0",
               pc, fetch_req, dut.sp_q);
    end
    checks++;
    if (instr !== 8'h00 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ack got %h/%b exp 00/0", instr, instr_valid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 0;
    test_reset();
    test_sequential();
    test_call_ret();
    test_overflow();
    test_reset();
    test_redirect();
    test_stall_stop();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
